// File: rtl/util_axis_data_width_packer.sv
// Narrow-to-wide AXI-Stream packer: collects RATIO slave beats into one master beat,
// flushing early on s_axis_tlast with m_axis_tkeep marking the valid bytes.
module util_axis_data_width_packer #(
  parameter int slave_width  = 2,
  parameter int master_width = 16
) (
  input  logic                      aclk,
  input  logic                      arstn,
  input  logic [slave_width*8-1:0]  s_axis_tdata,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic [master_width*8-1:0] m_axis_tdata,
  output logic [master_width-1:0]   m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready
);

  localparam int RATIO = master_width / slave_width;
  localparam int CNT_W = (RATIO < 2) ? 1 : $clog2(RATIO);
  localparam int SBITS = slave_width * 8;
  localparam int MBITS = master_width * 8;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(RATIO - 1);

  if ((slave_width < 1) || (master_width % slave_width != 0) || (RATIO < 2)) begin : g_bad_params
    $error("util_axis_data_width_packer: master_width must be a multiple (>=2x) of slave_width");
  end

  // Byte enables for a word whose last filled slot is 'slot'.
  function automatic logic [master_width-1:0] f_keep(input logic [CNT_W-1:0] slot);
    logic [master_width-1:0] keep;
    keep = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (CNT_W'(i) <= slot) keep[i*slave_width +: slave_width] = '1;
    end
    return keep;
  endfunction

  logic [CNT_W-1:0]        r_slot;
  logic [MBITS-1:0]        r_acc;
  logic [MBITS-1:0]        r_tdata;
  logic [master_width-1:0] r_tkeep;
  logic                    r_tlast;
  logic                    r_tvalid;

  logic                    w_accept;
  logic                    w_complete;
  logic                    w_drain;
  logic [MBITS-1:0]        w_merged;

  assign s_axis_tready = arstn & (~r_tvalid | m_axis_tready);
  assign w_accept      = s_axis_tvalid & s_axis_tready;
  assign w_complete    = w_accept & (s_axis_tlast | (r_slot == LAST_SLOT));
  assign w_drain       = r_tvalid & m_axis_tready;

  // Slots above r_slot are always zero in the accumulator, so unused upper bytes stay 0.
  always_comb begin
    w_merged = r_acc;
    for (int k = 0; k < RATIO; k++) begin
      if (r_slot == CNT_W'(k)) w_merged[k*SBITS +: SBITS] = s_axis_tdata;
    end
  end

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      r_slot <= '0;
      r_acc  <= '0;
    end else if (w_complete) begin
      r_slot <= '0;
      r_acc  <= '0;
    end else if (w_accept) begin
      r_slot <= r_slot + CNT_W'(1);
      r_acc  <= w_merged;
    end
  end

  // A completing beat may replace a word being drained on the same edge.
  always_ff @(posedge aclk) begin
    if (!arstn) begin
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tlast  <= 1'b0;
      r_tvalid <= 1'b0;
    end else if (w_complete) begin
      r_tdata  <= w_merged;
      r_tkeep  <= f_keep(r_slot);
      r_tlast  <= s_axis_tlast;
      r_tvalid <= 1'b1;
    end else if (w_drain) begin
      r_tvalid <= 1'b0;
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tkeep  = r_tkeep;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tvalid = r_tvalid;

endmodule

// File: tb/tb_util_axis_data_width_packer.sv
// Bench for util_axis_data_width_packer (2-byte slave, 16-byte master): directed steps
// plus randomized backpressure, checked against a packet-level reference model.
module tb_util_axis_data_width_packer;

  localparam int SW    = 2;
  localparam int MW    = 16;
  localparam int RATIO = MW / SW;

  logic           aclk = 1'b0;
  logic           arstn;
  logic [15:0]    s_tdata;
  logic           s_tvalid;
  logic           s_tlast;
  logic           s_tready;
  logic [127:0]   m_tdata;
  logic [15:0]    m_tkeep;
  logic           m_tlast;
  logic           m_tvalid;
  logic           m_tready;

  util_axis_data_width_packer #(.slave_width(SW), .master_width(MW)) dut (
    .aclk          (aclk),
    .arstn         (arstn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
  } word_t;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           n_words  = 0;
  int           stall_cnt = 0;
  bit           rand_mode = 0;
  logic [127:0] last_d;
  logic [15:0]  beats[$];
  word_t        expq[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: a packet is a list of beats; a word closes at RATIO beats or tlast.
  always @(negedge aclk) begin
    if (!arstn) begin
      beats.delete();
      expq.delete();
    end else begin
      if (m_tvalid && m_tready) begin
        if (expq.size() == 0) begin
          check("unexpected_word", 128'd1, 128'd0);
        end else begin
          word_t w;
          w = expq.pop_front();
          check("word_data", m_tdata, w.d);
          check("word_keep", {112'd0, m_tkeep}, {112'd0, w.k});
          check("word_last", {127'd0, m_tlast}, {127'd0, w.l});
        end
        n_words++;
        last_d = m_tdata;
      end
      if (s_tvalid && s_tready) begin
        beats.push_back(s_tdata);
        if (beats.size() == RATIO || s_tlast) begin
          word_t w;
          w.d = '0;
          for (int i = 0; i < beats.size(); i++) w.d = w.d + (128'(beats[i]) << (16 * i));
          w.k = 16'((32'd1 << (SW * beats.size())) - 1);
          w.l = s_tlast;
          expq.push_back(w);
          beats.delete();
        end
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic l);
    int waited;
    waited = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    forever begin
      if (rand_mode) m_tready = 1'($urandom_range(0, 1));
      @(negedge aclk);
      if (s_tready) break;
      stall_cnt++;
      waited++;
      if (waited > 200) begin
        check("send_timeout", 128'd0, 128'd1);
        s_tvalid = 1'b0;
        return;
      end
      @(posedge aclk); #1;
    end
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  initial begin
    logic [127:0] snap_d;
    logic [15:0]  snap_k;
    logic         snap_l;
    int           w0;

    // Reset with a valid beat offered
    arstn = 1'b0; s_tvalid = 1'b1; s_tdata = 16'hDEAD; s_tlast = 1'b0; m_tready = 1'b1;
    repeat (4) begin
      @(negedge aclk);
      check("rst_s_ready", {127'd0, s_tready}, 128'd0);
      check("rst_m_valid", {127'd0, m_tvalid}, 128'd0);
      check("rst_m_keep",  {112'd0, m_tkeep}, 128'd0);
      check("rst_m_data",  m_tdata, 128'd0);
    end
    @(posedge aclk); #1;
    arstn = 1'b1; s_tvalid = 1'b0;

    // Full-rate packing
    stall_cnt = 0;
    for (int i = 0; i < 8; i++) send(16'h5500 + 16'(i), i == 7);
    check("full_stalls", 128'(stall_cnt), 128'd0);
    @(negedge aclk);
    check("full_data",  m_tdata, 128'h5507550655055504550355025501_5500);
    check("full_keep",  {112'd0, m_tkeep}, {112'd0, 16'hFFFF});
    check("full_last",  {127'd0, m_tlast}, 128'd1);
    check("full_valid", {127'd0, m_tvalid}, 128'd1);
    @(posedge aclk); #1;

    // Early flush
    send(16'hAA01, 1'b0);
    send(16'hAA02, 1'b0);
    send(16'hAA03, 1'b1);
    @(negedge aclk);
    check("flush_data", m_tdata, {80'd0, 48'hAA03AA02AA01});
    check("flush_keep", {112'd0, m_tkeep}, {112'd0, 16'h003F});
    check("flush_last", {127'd0, m_tlast}, 128'd1);
    @(posedge aclk); #1;

    // Backpressure
    m_tready = 1'b0;
    for (int i = 0; i < 8; i++) send(16'hB000 + 16'(i), 1'b0);
    s_tdata = 16'hC000; s_tlast = 1'b0; s_tvalid = 1'b1;
    @(negedge aclk);
    check("bp_valid", {127'd0, m_tvalid}, 128'd1);
    check("bp_keep",  {112'd0, m_tkeep}, {112'd0, 16'hFFFF});
    snap_d = m_tdata; snap_k = m_tkeep; snap_l = m_tlast;
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      check("bp_hold_data",  m_tdata, snap_d);
      check("bp_hold_keep",  {112'd0, m_tkeep}, {112'd0, snap_k});
      check("bp_hold_last",  {127'd0, m_tlast}, {127'd0, snap_l});
      check("bp_hold_valid", {127'd0, m_tvalid}, 128'd1);
      check("bp_s_ready",    {127'd0, s_tready}, 128'd0);
    end
    @(posedge aclk); #1;
    m_tready = 1'b1;
    @(negedge aclk);
    check("bp_release_ready", {126'd0, s_tready, m_tvalid}, 128'd3);
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
    @(negedge aclk);
    check("bp_drained", {127'd0, m_tvalid}, 128'd0);
    @(posedge aclk); #1;
    for (int i = 1; i < 8; i++) send(16'hC000 + 16'(i), i == 7);
    @(posedge aclk); #1;

    // Random backpressure over 64 continuous beats
    w0 = n_words;
    rand_mode = 1;
    for (int i = 0; i < 64; i++) send(16'h2000 + 16'(i), 1'b0);
    rand_mode = 0;
    m_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("rand_word_count", 128'(n_words - w0), 128'd8);
    check("rand_queue_empty", 128'(expq.size()), 128'd0);

    // Reset mid-packet
    for (int i = 0; i < 5; i++) send(16'h0F00 + 16'(i), 1'b0);
    arstn = 1'b0;
    @(negedge aclk);
    check("midrst_s_ready", {127'd0, s_tready}, 128'd0);
    @(posedge aclk); #1;
    arstn = 1'b1;
    w0 = n_words;
    for (int i = 0; i < 8; i++) send(16'h0100 + 16'(i), i == 7);
    repeat (3) @(posedge aclk);
    #1;
    check("midrst_word_count", 128'(n_words - w0), 128'd1);
    check("midrst_word_data", last_d, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
    check("final_queue_empty", 128'(expq.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/util_axis_data_width_packer.md
Name: util_axis_data_width_packer

Overview:
- Narrow-to-wide AXI-Stream packer: gathers consecutive narrow slave beats into one wide master beat.
- Counterpart of the existing wide-to-narrow width conversion path; used on the receive side to rebuild wide words after a serializing stage.
- Adds tlast-driven early flush with tkeep marking the valid bytes, so packets that are not a multiple of the ratio are not stalled or padded silently.

Parameters:
- slave_width, 2, slave data width in bytes.
- master_width, 16, master data width in bytes; must be an integer multiple of slave_width.
- Derived localparam RATIO = master_width/slave_width; RATIO >= 2 is required.
- Any violation of these constraints is an elaboration-time $error.

Ports:
- aclk  in  1  stream clock; all logic on the rising edge.
- arstn  in  1  reset, synchronous, active-low.
- s_axis_tdata  in  slave_width*8  narrow input data.
- s_axis_tvalid  in  1  input valid.
- s_axis_tlast  in  1  input end of packet; forces a flush.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  master_width*8  packed output data.
- m_axis_tkeep  out  master_width  byte enables of the output word.
- m_axis_tlast  out  1  output end of packet.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.

Behaviour:
- Reset (arstn low at a rising edge):
  - slot counter = 0; accumulator = 0; partial word is discarded.
  - m_axis_tdata = 0, m_axis_tkeep = 0, m_axis_tlast = 0, m_axis_tvalid = 0.
  - s_axis_tready reads 0 while arstn is low.
- Handshake:
  - s_axis_tready = arstn & (~m_axis_tvalid | m_axis_tready), combinational.
  - A beat is accepted when s_axis_tvalid & s_axis_tready at the edge.
  - A beat is emitted when m_axis_tvalid & m_axis_tready.
- Packing:
  - Little-endian: the beat in slot k occupies bytes [k*slave_width +: slave_width].
  - Slot 0 lands in the least significant bytes.
- Slot counter:
  - Counts 0..RATIO-1.
  - Increments on each accepted beat that does not complete a word.
  - Returns to 0 on a completing beat.
- Completing beat: an accepted beat with slot == RATIO-1 or with s_axis_tlast = 1.
- Load on a completing beat, at that edge:
  - The output register receives the accumulator merged with the current beat.
  - m_axis_tkeep has ones for bytes 0 .. (slot+1)*slave_width-1 and zeros above.
  - Unused upper bytes of m_axis_tdata are 0.
  - m_axis_tlast = s_axis_tlast; m_axis_tvalid = 1.
  - The accumulator is cleared.
- Latency: m_axis_tvalid rises on the same edge that accepts the completing beat, i.e. 0 cycles after acceptance, registered.
- Output hold: while m_axis_tvalid & ~m_axis_tready, all m_axis_* signals are stable and s_axis_tready = 0.
- Simultaneous drain and load: when the output is drained while a completing beat is accepted on the same edge, the new word replaces the old one and m_axis_tvalid stays 1.
  - Sustained throughput is 1 slave beat per cycle when m_axis_tready = 1.
- Drain without load: m_axis_tvalid goes to 0 on that edge.
- Single-beat packet: tlast on slot 0 produces m_axis_tkeep = lower slave_width bits set.
- Full word with tlast: tlast on slot RATIO-1 produces all-ones m_axis_tkeep and tlast = 1.
- Non-completing beats do not modify the output register.
- Idle input (s_axis_tvalid low) holds all state; there is no timeout flush.
- Reset mid-packet drops both the accumulator and any pending output word. After reset the first accepted beat is slot 0.

Decomposition:
- No shared package. RATIO and the counter width CNT_W = clog2(RATIO) are module localparams.
- The tkeep generation is a function inside the module.
- Single flat module; no sub-module is warranted.

Test Plan (all with slave_width=2, master_width=16, RATIO=8):
- Reset: hold arstn low 4 cycles while s_axis_tvalid=1 -> s_axis_tready=0, m_axis_tvalid=0, m_axis_tkeep=0, and no beat is accepted.
- Full-rate packing: 8 beats 16'h5500..16'h5507, tlast on the 8th, m_axis_tready=1 -> one word 128'h5507550655055504550355025501_5500, tkeep=16'hFFFF, tlast=1, and no stall cycles.
- Early flush: 3 beats 16'hAA01, 16'hAA02, 16'hAA03 with tlast on the 3rd -> tdata low 48 bits = 48'hAA03AA02AA01, upper bits 0, tkeep=16'h003F, tlast=1.
- Backpressure: m_axis_tready held 0 for 10 cycles after a word is emitted -> m_axis_* stay stable and s_axis_tready=0 throughout. Raising ready gives drain and the next accept on the same edge.
- Random m_axis_tready ($random%2) with continuous incrementing input over 64 beats -> the scoreboard sees 8 words, byte-exact, in order, with no loss or duplication.
- Reset mid-packet: after 5 beats, pulse arstn low 1 cycle, then send 8 beats 16'h0100..16'h0107 -> exactly one output word containing only the post-reset beats.
